// File: rtl/avalon_mem_burst_splitter_pkg.sv
// Shared types and helpers for the Avalon-MM burst splitter.
// Burst limits are expressed as 2**(count_width-1), matching Avalon burstcount encoding.
package avalon_mem_burst_splitter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_SPLIT = 2'd1,
    WR_SPLIT = 2'd2
  } t_split_state;

  function automatic int unsigned fiu_max(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  function automatic int unsigned min_burst(input int unsigned rem, input int unsigned max);
    return (rem < max) ? rem : max;
  endfunction

endpackage

// File: rtl/avalon_mem_cmd_reg.sv
// Loadable FIU command register; a held command stays put while the FIU stalls it.
// Drains (read/write drop) when accepted with nothing new to load.
module avalon_mem_cmd_reg
  import avalon_mem_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 512,
  parameter int BC_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fiu_waitrequest_i,
  input  logic                    load_i,
  input  logic                    rd_i,
  input  logic                    wr_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [BC_WIDTH-1:0]     bc_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    can_load_o,
  output logic                    occupied_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [ADDR_WIDTH-1:0]   address_o,
  output logic [BC_WIDTH-1:0]     burstcount_o,
  output logic [DATA_WIDTH-1:0]   writedata_o,
  output logic [DATA_WIDTH/8-1:0] byteenable_o
);

  logic                    read_q, write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BC_WIDTH-1:0]     bc_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] be_q;

  assign occupied_o = read_q | write_q;
  assign can_load_o = !occupied_o || !fiu_waitrequest_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      bc_q    <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else if (load_i) begin
      read_q  <= rd_i;
      write_q <= wr_i;
      addr_q  <= addr_i;
      bc_q    <= bc_i;
      data_q  <= data_i;
      be_q    <= be_i;
    end else if (can_load_o) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign read_o       = read_q;
  assign write_o      = write_q;
  assign address_o    = addr_q;
  assign burstcount_o = bc_q;
  assign writedata_o  = data_q;
  assign byteenable_o = be_q;

endmodule

// File: rtl/avalon_mem_burst_splitter.sv
// Splits AFU Avalon-MM bursts into FIU-sized sub-bursts; read data returns through one register.
// state    | meaning
// IDLE     | waiting for a new AFU command
// RD_SPLIT | issuing remaining sub-reads, AFU stalled
// WR_SPLIT | forwarding remaining write beats, re-addressing at sub-burst boundaries
module avalon_mem_burst_splitter
  import avalon_mem_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH          = 27,
  parameter int DATA_WIDTH          = 512,
  parameter int AFU_BURST_CNT_WIDTH = 7,
  parameter int FIU_BURST_CNT_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic                           afu_waitrequest,
  output logic [DATA_WIDTH-1:0]          afu_readdata,
  output logic                           afu_readdatavalid,
  input  logic [AFU_BURST_CNT_WIDTH-1:0] afu_burstcount,
  input  logic [DATA_WIDTH-1:0]          afu_writedata,
  input  logic [ADDR_WIDTH-1:0]          afu_address,
  input  logic                           afu_write,
  input  logic                           afu_read,
  input  logic [DATA_WIDTH/8-1:0]        afu_byteenable,
  input  logic                           fiu_waitrequest,
  input  logic [DATA_WIDTH-1:0]          fiu_readdata,
  input  logic                           fiu_readdatavalid,
  output logic [FIU_BURST_CNT_WIDTH-1:0] fiu_burstcount,
  output logic [DATA_WIDTH-1:0]          fiu_writedata,
  output logic [ADDR_WIDTH-1:0]          fiu_address,
  output logic                           fiu_write,
  output logic                           fiu_read,
  output logic [DATA_WIDTH/8-1:0]        fiu_byteenable
);

  localparam int unsigned FIU_MAX = fiu_max(FIU_BURST_CNT_WIDTH);
  localparam int unsigned AFU_MAX = fiu_max(AFU_BURST_CNT_WIDTH);
  localparam logic [AFU_BURST_CNT_WIDTH-1:0] AFU_FIU_MAX = AFU_BURST_CNT_WIDTH'(FIU_MAX);
  localparam logic [ADDR_WIDTH-1:0]          ADDR_FIU_MAX = ADDR_WIDTH'(FIU_MAX);

  function automatic logic [FIU_BURST_CNT_WIDTH-1:0] sub_len(input logic [AFU_BURST_CNT_WIDTH-1:0] n);
    return FIU_BURST_CNT_WIDTH'(min_burst(32'(n), FIU_MAX));
  endfunction

  t_split_state                   state_q, state_d;
  logic [AFU_BURST_CNT_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]          nxt_q, nxt_d;
  logic [FIU_BURST_CNT_WIDTH-1:0] beat_q, beat_d;
  logic                           rdv_q;
  logic [DATA_WIDTH-1:0]          rdata_q;

  logic                           can_load, occupied, accept;
  logic                           ld, ld_rd, ld_wr;
  logic [ADDR_WIDTH-1:0]          ld_addr;
  logic [FIU_BURST_CNT_WIDTH-1:0] ld_bc;

  assign afu_waitrequest = (occupied && fiu_waitrequest) || (state_q == RD_SPLIT);
  assign accept = !afu_waitrequest &&
                  ((state_q == WR_SPLIT) ? afu_write : (afu_read || afu_write));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    nxt_d   = nxt_q;
    beat_d  = beat_q;
    ld      = 1'b0;
    ld_rd   = 1'b0;
    ld_wr   = 1'b0;
    ld_addr = fiu_address;
    ld_bc   = fiu_burstcount;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ld      = 1'b1;
          ld_addr = afu_address;
          ld_bc   = sub_len(afu_burstcount);
          if (afu_read) begin
            ld_rd = 1'b1;
            if (afu_burstcount > AFU_FIU_MAX) begin
              rem_d   = afu_burstcount - AFU_FIU_MAX;
              nxt_d   = afu_address + ADDR_FIU_MAX;
              state_d = RD_SPLIT;
            end
          end else begin
            ld_wr  = 1'b1;
            rem_d  = afu_burstcount - AFU_BURST_CNT_WIDTH'(1);
            beat_d = FIU_BURST_CNT_WIDTH'(1);
            nxt_d  = afu_address + ADDR_WIDTH'(ld_bc);
            if (afu_burstcount > AFU_BURST_CNT_WIDTH'(1)) state_d = WR_SPLIT;
          end
        end
      end
      RD_SPLIT: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_rd   = 1'b1;
          ld_addr = nxt_q;
          ld_bc   = sub_len(rem_q);
          rem_d   = rem_q - AFU_BURST_CNT_WIDTH'(ld_bc);
          nxt_d   = nxt_q + ADDR_WIDTH'(ld_bc);
          if (rem_q <= AFU_FIU_MAX) state_d = IDLE;
        end
      end
      WR_SPLIT: begin
        if (accept) begin
          ld    = 1'b1;
          ld_wr = 1'b1;
          // A full sub-burst has gone out; the next beat opens a fresh one.
          if (beat_q == fiu_burstcount) begin
            ld_addr = nxt_q;
            ld_bc   = sub_len(rem_q);
            nxt_d   = nxt_q + ADDR_WIDTH'(ld_bc);
            beat_d  = FIU_BURST_CNT_WIDTH'(1);
          end else begin
            beat_d  = beat_q + FIU_BURST_CNT_WIDTH'(1);
          end
          rem_d = rem_q - AFU_BURST_CNT_WIDTH'(1);
          if (rem_q == AFU_BURST_CNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      nxt_q   <= '0;
      beat_q  <= '0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nxt_q   <= nxt_d;
      beat_q  <= beat_d;
      rdv_q   <= fiu_readdatavalid;
      rdata_q <= fiu_readdata;
    end
  end

  assign afu_readdatavalid = rdv_q;
  assign afu_readdata      = rdata_q;

  avalon_mem_cmd_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BC_WIDTH   (FIU_BURST_CNT_WIDTH)
  ) u_cmd_reg (
    .clk               (clk),
    .reset_n           (reset_n),
    .fiu_waitrequest_i (fiu_waitrequest),
    .load_i            (ld),
    .rd_i              (ld_rd),
    .wr_i              (ld_wr),
    .addr_i            (ld_addr),
    .bc_i              (ld_bc),
    .data_i            (afu_writedata),
    .be_i              (afu_byteenable),
    .can_load_o        (can_load),
    .occupied_o        (occupied),
    .read_o            (fiu_read),
    .write_o           (fiu_write),
    .address_o         (fiu_address),
    .burstcount_o      (fiu_burstcount),
    .writedata_o       (fiu_writedata),
    .byteenable_o      (fiu_byteenable)
  );

  a_bc_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
    (afu_read || afu_write) |-> (afu_burstcount != '0));
  a_bc_max: assert property (@(posedge clk) disable iff (!reset_n)
    (afu_read || afu_write) |-> (32'(afu_burstcount) <= AFU_MAX));
  a_no_rd_in_wr: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == WR_SPLIT) |-> !afu_read);
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(afu_read && afu_write));

endmodule
